// File: rtl/ram_port_arbiter.sv
// Registered request/grant arbiter sharing one single-port RAM among a writer (0) and two readers (1, 2).
// Provides round-robin fairness, burst locking and out-of-range rejection.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 100
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2:0]            req,
  input  logic [2:0]            lock,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [2:0]            err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [0:0] {ARB = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state;
  logic [1:0]            owner;
  logic [1:0]            ptr;
  logic [2:0]            pick;
  logic                  win_valid;
  logic [1:0]            win;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  in_range;
  logic [2:0]            onehot;

  // Returns {found, index} of the first asserted request searching p, p+1, p+2 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    case (p)
      2'd1:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
      2'd2:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
      default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
    endcase
    if (r[a]) begin
      rr_pick = {1'b1, a};
    end else if (r[b]) begin
      rr_pick = {1'b1, b};
    end else if (r[c]) begin
      rr_pick = {1'b1, c};
    end else begin
      rr_pick = 3'b000;
    end
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] w);
    case (w)
      2'd0:    next_ptr = 2'd1;
      2'd1:    next_ptr = 2'd2;
      default: next_ptr = 2'd0;
    endcase
  endfunction

  // Winner selection: only the lock owner is eligible while LOCKED.
  always_comb begin
    pick      = rr_pick(req, ptr);
    win_valid = 1'b0;
    win       = 2'd0;
    if (state == LOCKED) begin
      win_valid = req[owner] & lock[owner];
      win       = owner;
    end else begin
      win_valid = pick[2];
      win       = pick[1:0];
    end
    case (win)
      2'd1:    sel_addr = addr1;
      2'd2:    sel_addr = addr2;
      default: sel_addr = addr0;
    endcase
    in_range = ({1'b0, sel_addr} < DEPTH_L);
    onehot   = 3'b001 << win;
  end

  // Arbiter FSM with registered grant, strobe and read-return outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= ARB;
      owner     <= 2'd0;
      ptr       <= 2'd0;
      gnt       <= 3'b000;
      rvalid    <= 3'b000;
      err       <= 3'b000;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= {ADDR_WIDTH{1'b0}};
      ram_wdata <= {DATA_WIDTH{1'b0}};
      rdata     <= {DATA_WIDTH{1'b0}};
    end else begin
      gnt    <= 3'b000;
      err    <= 3'b000;
      ram_we <= 1'b0;
      ram_oe <= 1'b0;
      rvalid <= ram_oe ? gnt : 3'b000;
      if (ram_oe) begin
        rdata <= ram_rdata;
      end
      if (win_valid) begin
        if (in_range) begin
          gnt      <= onehot;
          ram_addr <= sel_addr;
          if (win == 2'd0) begin
            ram_we    <= 1'b1;
            ram_wdata <= wdata0;
          end else begin
            ram_oe <= 1'b1;
          end
        end else begin
          err <= onehot;
        end
      end
      case (state)
        ARB: begin
          if (win_valid) begin
            // A rejected access never takes the lock; the pointer moves on either way.
            if (in_range && lock[win]) begin
              state <= LOCKED;
              owner <= win;
            end else begin
              ptr <= next_ptr(win);
            end
          end
        end
        LOCKED: begin
          if (!win_valid) begin
            state <= ARB;
            ptr   <= next_ptr(owner);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed-vector bench for ram_port_arbiter with a small behavioural RAM.
module tb_ram_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 256;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [2:0]    req = 3'b000;
  logic [2:0]    lock = 3'b000;
  logic [AW-1:0] addr0 = 12'd0;
  logic [DW-1:0] wdata0 = 256'd0;
  logic [AW-1:0] addr1 = 12'd0;
  logic [AW-1:0] addr2 = 12'd0;
  logic [2:0]    gnt;
  logic [2:0]    rvalid;
  logic [DW-1:0] rdata;
  logic [2:0]    err;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_oe;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:127];
  int vectors = 0;
  int miscompares = 0;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(100)) dut (
    .CLK(CLK), .RST(RST), .req(req), .lock(lock),
    .addr0(addr0), .wdata0(wdata0), .addr1(addr1), .addr2(addr2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  assign ram_rdata = ram_oe ? mem[ram_addr[6:0]] : 256'd0;

  // RAM model: preloaded while reset is low, written on ram_we.
  always @(posedge CLK) begin
    if (!RST) begin
      mem[5]  <= 256'hA5;
      mem[9]  <= 256'h1234;
      mem[99] <= 256'hBEEF;
    end else if (ram_we) begin
      mem[ram_addr[6:0]] <= ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [2:0] rr_exp [0:5];
  int n;

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;
    addr0 = 12'd7; wdata0 = 256'hC0FFEE; addr1 = 12'd5; addr2 = 12'd9;

    // Reset held with all requests pending.
    req = 3'b111;
    repeat (3) step();
    check("rst_gnt",    256'(gnt),    256'(3'b000));
    check("rst_rvalid", 256'(rvalid), 256'(3'b000));
    check("rst_err",    256'(err),    256'(3'b000));
    check("rst_we",     256'(ram_we), 256'(1'b0));
    check("rst_oe",     256'(ram_oe), 256'(1'b0));
    check("rst_addr",   256'(ram_addr), 256'(12'd0));
    check("rst_rdata",  rdata, 256'd0);

    // Release with req=111 held: round-robin 0,1,2,0,1,2.
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rr_gnt%0d", i), 256'(gnt), 256'(rr_exp[i]));
      check($sformatf("rr_we%0d", i), 256'(ram_we), 256'(rr_exp[i] == 3'b001));
      check($sformatf("rr_oe%0d", i), 256'(ram_oe), 256'(rr_exp[i] != 3'b001));
      if (i == 2) begin
        check("rr_rvalid1", 256'(rvalid), 256'(3'b010));
        check("rr_rdata1",  rdata, 256'hA5);
      end
      if (i == 3) begin
        check("rr_rvalid2", 256'(rvalid), 256'(3'b100));
        check("rr_rdata2",  rdata, 256'h1234);
      end
    end
    req = 3'b000;
    step();
    check("idle_gnt",  256'(gnt), 256'(3'b000));
    check("idle_addr", 256'(ram_addr), 256'(12'd9));
    check("wr_mem7",   mem[7], 256'hC0FFEE);

    // Single read of word 5.
    req = 3'b010; addr1 = 12'd5;
    step();
    check("rd_gnt",  256'(gnt), 256'(3'b010));
    check("rd_oe",   256'(ram_oe), 256'(1'b1));
    check("rd_we",   256'(ram_we), 256'(1'b0));
    check("rd_addr", 256'(ram_addr), 256'(12'd5));
    req = 3'b000;
    step();
    check("rd_rvalid", 256'(rvalid), 256'(3'b010));
    check("rd_rdata",  rdata, 256'hA5);
    check("rd_gnt_off", 256'(gnt), 256'(3'b000));

    // Burst lock by requester 0 while requester 1 also asks.
    req = 3'b011; lock = 3'b001; addr0 = 12'd20; wdata0 = 256'h55;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("burst_gnt%0d", i), 256'(gnt), 256'(3'b001));
      check($sformatf("burst_we%0d", i), 256'(ram_we), 256'(1'b1));
    end
    req = 3'b010; lock = 3'b000;
    step();
    n = 0;
    while (gnt == 3'b000 && n < 4) begin
      step();
      n++;
    end
    check("burst_exit_gnt", 256'(gnt), 256'(3'b010));
    req = 3'b000;
    step();

    // Out-of-range read, then the last valid word.
    req = 3'b100; addr2 = 12'd100;
    step();
    check("oor_err", 256'(err), 256'(3'b100));
    check("oor_gnt", 256'(gnt), 256'(3'b000));
    check("oor_oe",  256'(ram_oe), 256'(1'b0));
    addr2 = 12'd99;
    step();
    check("inr_err",  256'(err), 256'(3'b000));
    check("inr_gnt",  256'(gnt), 256'(3'b100));
    check("inr_addr", 256'(ram_addr), 256'(12'd99));
    req = 3'b000;
    step();
    check("inr_rvalid", 256'(rvalid), 256'(3'b100));
    check("inr_rdata",  rdata, 256'hBEEF);

    // Move the pointer to 1, then start a locked write burst and reset mid-burst.
    req = 3'b001; addr0 = 12'd3; wdata0 = 256'h77;
    step();
    check("pre_gnt", 256'(gnt), 256'(3'b001));
    req = 3'b000;
    step();
    req = 3'b001; lock = 3'b001;
    step();
    check("mb_gnt0", 256'(gnt), 256'(3'b001));
    step();
    check("mb_gnt1", 256'(gnt), 256'(3'b001));
    RST = 1'b0;
    step();
    check("mb_rst_gnt", 256'(gnt), 256'(3'b000));
    check("mb_rst_we",  256'(ram_we), 256'(1'b0));
    RST = 1'b1; req = 3'b111; lock = 3'b000;
    step();
    check("mb_restart_gnt", 256'(gnt), 256'(3'b001));
    req = 3'b000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
